// File: rtl/crypto_pkg.sv
// Shared definitions for the crypto output serializer slice.
//   - byte/word widths of the output path
//   - default FIFO depth and frame length
//   - serializer FSM state encoding
package crypto_pkg;

   localparam int BYTE_W            = 8;
   localparam int WORD_W            = 16;
   localparam int DEFAULT_DEPTH     = 4;
   localparam int DEFAULT_FRAME_LEN = 4;

   // CK_* states are only entered when CRYPTO_OUT_CHECKSUM_EN is defined.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HI    = 3'd1,
      ST_LO    = 3'd2,
      ST_CK_HI = 3'd3,
      ST_CK_LO = 3'd4
   } ser_state_e;

endpackage

// File: rtl/crypto_sync_fifo.sv
// Synchronous FIFO holding ciphertext words ahead of the serializer.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   push         : write push_data (ignored while full)
//   push_data    : word to store
//   pop          : remove the head word (ignored while empty)
//   pop_data     : current head word (valid while !empty)
//   full, empty  : occupancy flags
//   count        : number of stored words, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module crypto_sync_fifo
   import crypto_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = WORD_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage carries no reset; only pointers and count define occupancy.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/crypto_out_serializer.sv
// Serializes 16-bit ciphertext words into a byte stream, high byte first,
// grouped into frames of FRAME_LEN words.
// Build option: CRYPTO_OUT_CHECKSUM_EN appends a 2-byte XOR checksum of the
// frame's words after every frame; without it frames carry data bytes only.
// Ports:
//   clk, rst    : clock, synchronous active-low reset
//   in_data     : ciphertext word
//   in_valid    : in_data present this cycle
//   in_ready    : FIFO can take a word this cycle (word accepted on valid&&ready)
//   out_byte    : serialized byte (registered)
//   out_valid   : out_byte valid (registered)
//   out_ready   : downstream accepts out_byte (byte moves on valid&&ready)
//   out_last    : out_byte is the final byte of a frame
//   overflow    : sticky, a word was offered while the FIFO was full
//   dbg_state   : current FSM state (crypto_pkg::ser_state_e encoding)
// Handshakes: a transfer happens on any rising edge where valid and ready are
// both high; a source holds its data stable while valid is high and ready low.
module crypto_out_serializer
   import crypto_pkg::*;
#(
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [BYTE_W-1:0] out_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              overflow,
   output logic [2:0]        dbg_state
);

   localparam int            CW       = $clog2(DEPTH) + 1;
   localparam logic [7:0]    LAST_IDX = 8'(FRAME_LEN - 1);

   logic [WORD_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic              push;
   logic              pop;

   ser_state_e        state, state_n;
   logic [WORD_W-1:0] word_q, word_n;
   logic [7:0]        cnt_q, cnt_n;
   logic              frame_end;
   logic              next_word;
`ifdef CRYPTO_OUT_CHECKSUM_EN
   logic [WORD_W-1:0] csum_q, csum_n;
`endif

   logic              ov_n;
   logic [BYTE_W-1:0] ob_n;
   logic              ol_n;

   // No pop bypass: a full FIFO refuses input even if the FSM pops this cycle.
   assign in_ready  = (fifo_count != CW'(DEPTH));
   assign push      = in_valid && in_ready;
   assign dbg_state = state;

   crypto_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Next-state logic. A finished word either fetches the next one straight
   // into HI (no bubble) or falls back to IDLE; a finished frame also clears
   // the word count and checksum before that fetch.
   always_comb begin
      state_n   = state;
      word_n    = word_q;
      cnt_n     = cnt_q;
      pop       = 1'b0;
      frame_end = 1'b0;
      next_word = 1'b0;
`ifdef CRYPTO_OUT_CHECKSUM_EN
      csum_n    = csum_q;
`endif
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               word_n  = fifo_head;
`ifdef CRYPTO_OUT_CHECKSUM_EN
               csum_n  = csum_q ^ fifo_head;
`endif
               state_n = ST_HI;
            end
         end
         ST_HI: begin
            if (out_ready) state_n = ST_LO;
         end
         ST_LO: begin
            if (out_ready) begin
               if (cnt_q == LAST_IDX) begin
`ifdef CRYPTO_OUT_CHECKSUM_EN
                  cnt_n   = cnt_q + 8'd1;
                  state_n = ST_CK_HI;
`else
                  frame_end = 1'b1;
`endif
               end else begin
                  cnt_n     = cnt_q + 8'd1;
                  next_word = 1'b1;
               end
            end
         end
`ifdef CRYPTO_OUT_CHECKSUM_EN
         ST_CK_HI: begin
            if (out_ready) state_n = ST_CK_LO;
         end
         ST_CK_LO: begin
            if (out_ready) frame_end = 1'b1;
         end
`endif
         default: state_n = ST_IDLE;
      endcase

      if (frame_end) begin
         cnt_n     = 8'd0;
`ifdef CRYPTO_OUT_CHECKSUM_EN
         csum_n    = '0;
`endif
         next_word = 1'b1;
      end

      if (next_word) begin
         if (!fifo_empty) begin
            pop     = 1'b1;
            word_n  = fifo_head;
`ifdef CRYPTO_OUT_CHECKSUM_EN
            csum_n  = csum_n ^ fifo_head;
`endif
            state_n = ST_HI;
         end else begin
            state_n = ST_IDLE;
         end
      end
   end

   // Output bytes are decoded from the next state so they can be registered
   // alongside it; this keeps them stable for as long as the state is held.
   always_comb begin
      ov_n = 1'b0;
      ob_n = '0;
      ol_n = 1'b0;
      case (state_n)
         ST_HI: begin
            ov_n = 1'b1;
            ob_n = word_n[15:8];
         end
         ST_LO: begin
            ov_n = 1'b1;
            ob_n = word_n[7:0];
`ifndef CRYPTO_OUT_CHECKSUM_EN
            ol_n = (cnt_n == LAST_IDX);
`endif
         end
`ifdef CRYPTO_OUT_CHECKSUM_EN
         ST_CK_HI: begin
            ov_n = 1'b1;
            ob_n = csum_n[15:8];
         end
         ST_CK_LO: begin
            ov_n = 1'b1;
            ob_n = csum_n[7:0];
            ol_n = 1'b1;
         end
`endif
         default: begin
            ov_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         word_q    <= '0;
         cnt_q     <= '0;
`ifdef CRYPTO_OUT_CHECKSUM_EN
         csum_q    <= '0;
`endif
         out_valid <= 1'b0;
         out_byte  <= '0;
         out_last  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_n;
         word_q    <= word_n;
         cnt_q     <= cnt_n;
`ifdef CRYPTO_OUT_CHECKSUM_EN
         csum_q    <= csum_n;
`endif
         out_valid <= ov_n;
         out_byte  <= ob_n;
         out_last  <= ol_n;
         // Offered word is dropped; the flag stays until reset.
         overflow  <= overflow | (in_valid && fifo_full);
      end
   end

endmodule

// File: tb/tb_crypto_out_serializer.sv
// Directed bench for crypto_out_serializer. Handles both builds of
// CRYPTO_OUT_CHECKSUM_EN (frame length 4 with checksum, 2 without).
module tb_crypto_out_serializer;

`ifdef CRYPTO_OUT_CHECKSUM_EN
   localparam int FL     = 4;
   localparam bit CK_ON  = 1'b1;
`else
   localparam int FL     = 2;
   localparam bit CK_ON  = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        overflow;
   logic [2:0]  dbg_state;

   crypto_out_serializer #(
      .DEPTH     (4),
      .FRAME_LEN (FL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_byte  (out_byte),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .overflow  (overflow),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [8:0]  exp_q[$];          // {last, byte}
   int          m_cnt  = 0;
   logic [15:0] m_csum = '0;
   bit          done   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model of one accepted word: queue its bytes and, at frame end,
   // the checksum bytes.
   task automatic model_word(input logic [15:0] w);
      exp_q.push_back({1'b0, w[15:8]});
      if (CK_ON) begin
         exp_q.push_back({1'b0, w[7:0]});
         m_csum = m_csum ^ w;
         m_cnt++;
         if (m_cnt == FL) begin
            exp_q.push_back({1'b0, m_csum[15:8]});
            exp_q.push_back({1'b1, m_csum[7:0]});
            m_cnt  = 0;
            m_csum = '0;
         end
      end else begin
         exp_q.push_back({(m_cnt == FL - 1), w[7:0]});
         m_cnt = (m_cnt == FL - 1) ? 0 : m_cnt + 1;
      end
   endtask

   // Monitor: compares every accepted byte and checks outputs hold during stalls.
   logic       prev_v, prev_r, prev_l;
   logic [7:0] prev_b;
   initial begin
      logic [8:0] e;
      prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_b = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_v = 1'b0;
         end else begin
            if (prev_v && !prev_r)
               check("stall_hold", {out_valid, out_last, out_byte}, {1'b1, prev_l, prev_b});
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_byte: got %0h last %0b, nothing expected", out_byte, out_last);
               end else begin
                  e = exp_q.pop_front();
                  check("out_byte_last", {out_last, out_byte}, e);
               end
            end
            prev_v = out_valid; prev_r = out_ready; prev_b = out_byte; prev_l = out_last;
         end
      end
   end

   // ---------------- driver tasks (enter and leave at posedge+1) ----------------
   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      m_cnt = 0; m_csum = '0;
   endtask

   task automatic push_word(input logic [15:0] w);
      bit acc;
      acc = 1'b0;
      in_valid = 1'b1; in_data = w;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) break;
      end
      in_valid = 1'b0;
      if (!acc) begin
         n_checks++; n_errors++;
         $display("FAIL push_timeout: word %0h not accepted, required accept", w);
      end
   endtask

   task automatic wait_drain(input int budget);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < budget) begin
         @(posedge clk); t++;
      end
      #1;
      check("drain_left", exp_q.size(), 0);
      @(negedge clk);
      check("drain_idle_valid", out_valid, 1'b0);
      @(posedge clk); #1;
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [15:0] word;
      logic [7:0]  hi;
      logic [7:0]  lo;
      bit          end2;   // ends a 2-word frame
      bit          end4;   // ends a 4-word frame
      logic [15:0] csum4;  // checksum of the 4-word frame it ends
   } vec_t;

   vec_t        vecs[8];
   logic [15:0] stall_w[6];

   initial begin
      bit [5:0] acc_bits;
      int       run;
      vecs[0] = '{16'h1234, 8'h12, 8'h34, 1'b0, 1'b0, 16'h0000};
      vecs[1] = '{16'h00FF, 8'h00, 8'hFF, 1'b1, 1'b0, 16'h0000};
      vecs[2] = '{16'hF0F0, 8'hF0, 8'hF0, 1'b0, 1'b0, 16'h0000};
      vecs[3] = '{16'h0001, 8'h00, 8'h01, 1'b1, 1'b1, 16'hE23A};
      vecs[4] = '{16'h0102, 8'h01, 8'h02, 1'b0, 1'b0, 16'h0000};
      vecs[5] = '{16'h0304, 8'h03, 8'h04, 1'b1, 1'b0, 16'h0000};
      vecs[6] = '{16'hABCD, 8'hAB, 8'hCD, 1'b0, 1'b0, 16'h0000};
      vecs[7] = '{16'h5A5A, 8'h5A, 8'h5A, 1'b1, 1'b1, 16'hF391};
      stall_w[0] = 16'h1357; stall_w[1] = 16'h2468; stall_w[2] = 16'h9ABC;
      stall_w[3] = 16'hDEF0; stall_w[4] = 16'h0F0F; stall_w[5] = 16'hCAFE;

      rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // reset state
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_byte",  out_byte,  8'h00);
      check("rst_out_last",  out_last,  1'b0);
      check("rst_overflow",  overflow,  1'b0);
      check("rst_in_ready",  in_ready,  1'b1);
      check("rst_state",     dbg_state, 3'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // latency: word accepted at edge N, high byte visible in cycle N+2
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 16'hA55A;
      model_word(16'hA55A);
      @(negedge clk);
      check("lat_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("lat_n1_valid", out_valid, 1'b0);
      @(negedge clk);
      check("lat_n2_hi", {out_valid, out_byte}, {1'b1, 8'hA5});
      @(negedge clk);
      check("lat_n3_lo", {out_valid, out_byte}, {1'b1, 8'h5A});
      @(negedge clk);
      check("lat_n4_idle", out_valid, 1'b0);
      @(posedge clk); #1;
      do_reset();

      // table: hand-computed bytes and checksums, full-speed output
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({1'b0, vecs[i].hi});
         if (CK_ON) begin
            exp_q.push_back({1'b0, vecs[i].lo});
            if (vecs[i].end4) begin
               exp_q.push_back({1'b0, vecs[i].csum4[15:8]});
               exp_q.push_back({1'b1, vecs[i].csum4[7:0]});
            end
         end else begin
            exp_q.push_back({vecs[i].end2, vecs[i].lo});
         end
         push_word(vecs[i].word);
      end
      wait_drain(200);

      // stall: 6 words offered back-to-back with out_ready low
      do_reset();
      out_ready = 1'b0;
      acc_bits = '0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = stall_w[i];
         @(negedge clk);
         acc_bits[i] = in_ready;
         if (in_ready) model_word(stall_w[i]);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      check("stall_accept_pattern", acc_bits, 6'b011111);
      check("stall_in_ready",  in_ready,  1'b0);
      check("stall_overflow",  overflow,  1'b1);
      check("stall_head_byte", {out_valid, out_byte}, {1'b1, 8'h13});
      check("stall_state",     dbg_state, 3'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      run = 0;
      @(negedge clk);
      while (out_valid && run < 50) begin
         run++;
         @(negedge clk);
      end
      check("throughput_run", run, CK_ON ? 12 : 10);
      @(posedge clk); #1;
      wait_drain(50);
      check("overflow_sticky", overflow, 1'b1);
      do_reset();
      @(negedge clk);
      check("overflow_cleared", overflow, 1'b0);
      @(posedge clk); #1;

      // reset mid-frame (in CK_HI with checksum, in HI of word 2 without)
      out_ready = 1'b0;
      for (int i = 0; i < FL; i++) begin
         model_word(16'h1111 * (i + 1));
         push_word(16'h1111 * (i + 1));
      end
      out_ready = 1'b1;
      repeat (CK_ON ? 2 * FL : 2) @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("midframe_state", dbg_state, CK_ON ? 3'd3 : 3'd1);
      check("midframe_byte",  {out_valid, out_byte}, {1'b1, (CK_ON ? 8'h44 : 8'h22)});
      do_reset();
      @(negedge clk);
      check("midframe_rst_valid", out_valid, 1'b0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      model_word(16'h0F00); push_word(16'h0F00);
      model_word(16'h00F0); push_word(16'h00F0);
      if (CK_ON) begin
         model_word(16'h000F); push_word(16'h000F);
         model_word(16'hF000); push_word(16'hF000);
      end
      wait_drain(100);

      // random out_ready, random words, whole frames
      do_reset();
      done = 1'b0;
      fork
         begin
            logic [15:0] w;
            for (int i = 0; i < 12; i++) begin
               w = 16'($urandom_range(0, 16'hFFFF));
               model_word(w);
               push_word(w);
            end
            wait_drain(2000);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      repeat (3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
